// File: rtl/pc_gen.sv
// ----------------------------------------------------------------------------
// pc_gen -- fetch program-counter generator with a small return-address stack.
//
// Each unstalled cycle the fetch address advances to the highest-priority
// candidate: trap_vec > jalr target > jal/br target > addr+4. A redirect whose
// target is not word aligned is dropped: addr holds and misalign pulses.
// The RAS records addr+4 on calls and pops on returns; when full, a push
// overwrites the oldest entry.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset, beats every other input
//   stall      hold addr, misalign and the RAS (trap_en still redirects)
//   br_en      taken branch,   target = addr + jmp_to
//   jal_en     direct jump,    target = addr + jmp_to
//   jalr_en    register jump,  target = jmp_to with bit 0 cleared
//   trap_en    trap redirect,  target = trap_vec
//   jmp_to     branch/jal offset or jalr absolute target
//   trap_vec   trap handler address
//   call_hint  push addr+4 onto the RAS
//   ret_hint   pop the RAS
//   addr       registered fetch address
//   addr_vld   addr is a real fetch address (0 only while in reset)
//   misalign   previous cycle's selected redirect target was misaligned
//   ras_top    top RAS entry, 0 when empty
//   ras_empty  RAS holds no entries
//   ras_full   RAS holds RAS_DEPTH entries
// ----------------------------------------------------------------------------
module pc_gen #(
   parameter int unsigned      XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_VEC = '0,
   parameter int unsigned      RAS_DEPTH = 4   // power of 2, >= 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            br_en,
   input  logic            jal_en,
   input  logic            jalr_en,
   input  logic            trap_en,
   input  logic [XLEN-1:0] jmp_to,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            call_hint,
   input  logic            ret_hint,
   output logic [XLEN-1:0] addr,
   output logic            addr_vld,
   output logic            misalign,
   output logic [XLEN-1:0] ras_top,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam int unsigned   PW      = $clog2(RAS_DEPTH);
   localparam int unsigned   CW      = PW + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

   // Next-address decision: redir marks a target that must be alignment checked.
   typedef struct packed {
      logic            redir;
      logic [XLEN-1:0] tgt;
   } nxt_t;

   nxt_t            nxt;
   logic [XLEN-1:0] seq_addr;
   logic            advance;
   logic            tgt_mis;

   // ------------------------------------------------------------------------
   // Next fetch address
   // ------------------------------------------------------------------------
   assign seq_addr = addr + XLEN'(4);

   always_comb begin
      nxt.redir = 1'b0;
      nxt.tgt   = seq_addr;
      if (trap_en) begin
         nxt.redir = 1'b1;
         nxt.tgt   = trap_vec;
      end else if (jalr_en) begin
         nxt.redir = 1'b1;
         nxt.tgt   = {jmp_to[XLEN-1:1], 1'b0};
      end else if (jal_en | br_en) begin
         nxt.redir = 1'b1;
         nxt.tgt   = addr + jmp_to;
      end
   end

   // A trap still lands while stalled; everything else waits for the stall.
   assign advance = trap_en | ~stall;
   assign tgt_mis = nxt.redir & (nxt.tgt[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         addr     <= RESET_VEC;
         addr_vld <= 1'b0;
         misalign <= 1'b0;
      end else begin
         addr_vld <= 1'b1;
         if (advance) begin
            if (tgt_mis) begin
               misalign <= 1'b1;
            end else begin
               addr     <= nxt.tgt;
               misalign <= 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Return-address stack: circular buffer, ras_ptr indexes the top entry.
   // Overflow just advances the pointer, so the oldest entry is overwritten.
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [CW-1:0]   ras_cnt;
   logic [PW-1:0]   ptr_inc;
   logic            ras_op_en;
   logic            do_push;
   logic            do_repl;
   logic            do_pop;

   assign ras_op_en = ~stall & ~trap_en;
   assign ras_empty = (ras_cnt == '0);
   assign ras_full  = (ras_cnt == CNT_MAX);
   assign ptr_inc   = ras_ptr + PW'(1);

   // call+ret is a tail call: replace top, unless empty where it is a push.
   assign do_push = ras_op_en & call_hint & (~ret_hint | ras_empty);
   assign do_repl = ras_op_en & call_hint & ret_hint & ~ras_empty;
   assign do_pop  = ras_op_en & ret_hint & ~call_hint & ~ras_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else if (do_push) begin
         ras_ptr <= ptr_inc;
         if (!ras_full)
            ras_cnt <= ras_cnt + CW'(1);
      end else if (do_pop) begin
         ras_ptr <= ras_ptr - PW'(1);
         ras_cnt <= ras_cnt - CW'(1);
      end
   end

   // Entries are only ever read while counted, so they need no reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (do_push)
            ras_mem[ptr_inc] <= seq_addr;
         else if (do_repl)
            ras_mem[ras_ptr] <= seq_addr;
      end
   end

   assign ras_top = ras_empty ? '0 : ras_mem[ras_ptr];

endmodule

// File: tb/tb_pc_gen.sv
// ----------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (default parameters).
// Directed table of redirect/priority/stall/misalign/wrap cases, a hand
// sequence for the RAS corner cases, then randomized cycles compared against
// a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_pc_gen;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, stall, br_en, jal_en, jalr_en, trap_en, call_hint, ret_hint;
   logic [31:0] jmp_to, trap_vec;
   logic [31:0] addr, ras_top;
   logic        addr_vld, misalign, ras_empty, ras_full;

   int n_chk = 0;
   int n_err = 0;

   pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .br_en(br_en), .jal_en(jal_en),
      .jalr_en(jalr_en), .trap_en(trap_en), .jmp_to(jmp_to), .trap_vec(trap_vec),
      .call_hint(call_hint), .ret_hint(ret_hint), .addr(addr), .addr_vld(addr_vld),
      .misalign(misalign), .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] m_addr;
   logic        m_vld, m_mis;
   logic [31:0] m_q[$];   // back = top of stack

   task automatic model_step();
      logic [31:0] tgt;
      logic        redir;
      if (rst) begin
         m_addr = 32'h0; m_vld = 1'b0; m_mis = 1'b0; m_q.delete();
         return;
      end
      m_vld = 1'b1;
      if (!trap_en && stall) return;
      redir = 1'b1;
      if (trap_en)                tgt = trap_vec;
      else if (jalr_en)           tgt = jmp_to & ~32'h1;
      else if (jal_en || br_en)   tgt = m_addr + jmp_to;
      else begin                  tgt = m_addr + 32'd4; redir = 1'b0; end
      if (!trap_en) begin
         if (call_hint && ret_hint) begin
            if (m_q.size() == 0) m_q.push_back(m_addr + 32'd4);
            else m_q[m_q.size()-1] = m_addr + 32'd4;
         end else if (call_hint) begin
            m_q.push_back(m_addr + 32'd4);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
         end else if (ret_hint) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
         end
      end
      if (redir && (tgt % 4 != 0)) m_mis = 1'b1;
      else begin m_addr = tgt; m_mis = 1'b0; end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic r, s, b, j, jr, t, c, rt,
                      input logic [31:0] jt, tv);
      @(negedge clk);
      rst = r; stall = s; br_en = b; jal_en = j; jalr_en = jr; trap_en = t;
      call_hint = c; ret_hint = rt; jmp_to = jt; trap_vec = tv;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0,0,0,0,0,0,0,0, 32'h0, 32'h0);
   endtask

   // ---------------- directed table ----------------
   typedef struct packed {
      logic        s, b, j, jr, t;
      logic [31:0] jt, tv;
      logic [31:0] ea;
      logic        em;
   } vec_t;

   function automatic vec_t mk(input logic s, b, j, jr, t,
                               input logic [31:0] jt, tv, ea, input logic em);
      vec_t v;
      v.s = s; v.b = b; v.j = j; v.jr = jr; v.t = t;
      v.jt = jt; v.tv = tv; v.ea = ea; v.em = em;
      return v;
   endfunction

   vec_t tbl [16];

   initial begin
      //             s  b  j  jr t   jmp_to        trap_vec      exp addr      mis
      tbl[0]  = mk(0, 0, 1, 0, 0, 32'h100,      32'h0,        32'h100,      0);
      tbl[1]  = mk(0, 0, 1, 1, 0, 32'h41,       32'h0,        32'h40,       0); // jalr wins, bit0 cleared
      tbl[2]  = mk(0, 0, 1, 0, 0, 32'h1C0,      32'h0,        32'h200,      0);
      tbl[3]  = mk(1, 1, 0, 0, 0, 32'h10,       32'h0,        32'h200,      0); // stalled branch
      tbl[4]  = mk(1, 1, 0, 0, 0, 32'h10,       32'h0,        32'h200,      0);
      tbl[5]  = mk(1, 0, 0, 0, 1, 32'h0,        32'h800,      32'h800,      0); // trap beats stall
      tbl[6]  = mk(0, 0, 0, 1, 0, 32'h300,      32'h0,        32'h300,      0);
      tbl[7]  = mk(0, 1, 0, 0, 0, 32'h6,        32'h0,        32'h300,      1); // misaligned branch
      tbl[8]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h304,      0);
      tbl[9]  = mk(0, 1, 1, 0, 0, 32'hC,        32'h0,        32'h310,      0); // br+jal single result
      tbl[10] = mk(0, 0, 0, 0, 1, 32'h0,        32'h802,      32'h310,      1); // misaligned trap
      tbl[11] = mk(0, 0, 0, 1, 0, 32'h3,        32'h0,        32'h310,      1); // jalr -> 0x2
      tbl[12] = mk(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 0);
      tbl[13] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0); // wrap
      tbl[14] = mk(0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 0); // modulo add
      tbl[15] = mk(1, 1, 0, 1, 1, 32'h40,       32'h1000,     32'h1000,     0); // trap over all

      // ---- reset with everything else asserted ----
      cyc(1,1,1,1,1,1,1,1, 32'h44, 32'h900);
      chk("rst_addr",  addr,      32'h0);
      chk("rst_vld",   addr_vld,  1'b0);
      chk("rst_mis",   misalign,  1'b0);
      chk("rst_empty", ras_empty, 1'b1);
      chk("rst_full",  ras_full,  1'b0);
      chk("rst_top",   ras_top,   32'h0);

      // ---- reset release, sequential fetch ----
      for (int i = 1; i <= 3; i++) begin
         idle();
         chk("seq_addr", addr, 32'(4 * i));
         chk("seq_vld",  addr_vld, 1'b1);
      end

      // ---- directed table ----
      cyc(1,0,0,0,0,0,0,0, 32'h0, 32'h0);
      for (int i = 0; i < 16; i++) begin
         cyc(0, tbl[i].s, tbl[i].b, tbl[i].j, tbl[i].jr, tbl[i].t, 0, 0, tbl[i].jt, tbl[i].tv);
         chk($sformatf("tbl%0d_addr", i), addr, tbl[i].ea);
         chk($sformatf("tbl%0d_mis", i), misalign, tbl[i].em);
      end

      // ---- RAS corner sequence ----
      cyc(1,0,0,0,0,0,0,0, 32'h0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc(0,0,0,0,0,0,1,0, 32'h0, 32'h0);
         chk("ras_push_top",  ras_top,  32'(4 * (i + 1)));
         chk("ras_push_full", ras_full, (i >= 3) ? 1'b1 : 1'b0);
      end
      cyc(0,1,0,0,0,0,1,0, 32'h0, 32'h0);      // stalled call ignored
      chk("ras_stall_top", ras_top, 32'h14);
      chk("ras_stall_addr", addr, 32'h14);
      cyc(0,0,0,0,0,1,1,0, 32'h0, 32'h40);     // trap: RAS untouched
      chk("ras_trap_top", ras_top, 32'h14);
      chk("ras_trap_addr", addr, 32'h40);
      for (int i = 0; i < 4; i++) begin
         cyc(0,0,0,0,0,0,0,1, 32'h0, 32'h0);
         chk("ras_pop_top", ras_top, (i == 3) ? 32'h0 : 32'(16 - 4 * i));
      end
      chk("ras_pop_empty", ras_empty, 1'b1);
      cyc(0,0,0,0,0,0,0,1, 32'h0, 32'h0);      // pop on empty
      chk("ras_pop5_empty", ras_empty, 1'b1);
      chk("ras_pop5_full",  ras_full,  1'b0);
      chk("ras_pop5_top",   ras_top,   32'h0);
      cyc(0,0,0,0,0,0,1,1, 32'h0, 32'h0);      // call+ret on empty -> push
      chk("ras_cr_top",   ras_top,   32'h58);
      chk("ras_cr_empty", ras_empty, 1'b0);
      cyc(0,0,0,0,0,0,1,1, 32'h0, 32'h0);      // call+ret -> replace
      chk("ras_rep_top", ras_top, 32'h5C);
      cyc(0,0,0,0,0,0,0,1, 32'h0, 32'h0);      // single entry left
      chk("ras_rep_empty", ras_empty, 1'b1);

      // ---- randomized against the model ----
      cyc(1,0,0,0,0,0,0,0, 32'h0, 32'h0);
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] jt, tv;
         jt = ($urandom_range(0, 255) << 2) | (($urandom % 8 == 0) ? $urandom % 4 : 0);
         if ($urandom % 16 == 0) jt = $urandom;
         tv = ($urandom_range(0, 1023) << 2) | (($urandom % 8 == 0) ? $urandom % 4 : 0);
         cyc($urandom % 64 == 0, $urandom % 4 == 0, $urandom % 5 == 0, $urandom % 6 == 0,
             $urandom % 8 == 0, $urandom % 16 == 0, $urandom % 3 == 0, $urandom % 4 == 0,
             jt, tv);
         chk("rnd_addr",  addr,      m_addr);
         chk("rnd_vld",   addr_vld,  m_vld);
         chk("rnd_mis",   misalign,  m_mis);
         chk("rnd_empty", ras_empty, (m_q.size() == 0) ? 1'b1 : 1'b0);
         chk("rnd_full",  ras_full,  (m_q.size() == DEPTH) ? 1'b1 : 1'b0);
         chk("rnd_top",   ras_top,   (m_q.size() == 0) ? 32'h0 : m_q[m_q.size()-1]);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: width of all address/target ports.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000: addr value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of 2, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stall  input  1  hold current addr and RAS state.
REQ-007 br_en  input  1  taken conditional branch; target = addr + jmp_to.
REQ-008 jal_en  input  1  direct jump; target = addr + jmp_to.
REQ-009 jalr_en  input  1  register jump; target = jmp_to with bit 0 cleared.
REQ-010 trap_en  input  1  trap redirect; target = trap_vec.
REQ-011 jmp_to  input  XLEN  offset (br/jal) or absolute target (jalr).
REQ-012 trap_vec  input  XLEN  trap handler address.
REQ-013 call_hint  input  1  current instruction is a call; push addr+4 on RAS.
REQ-014 ret_hint  input  1  current instruction is a return; pop RAS.
REQ-015 addr  output  XLEN  current fetch address, registered.
REQ-016 addr_vld  output  1  addr is a valid fetch address.
REQ-017 misalign  output  1  registered flag: previous cycle's redirect target was misaligned.
REQ-018 ras_top  output  XLEN  RAS top entry; 0 when empty.
REQ-019 ras_empty / ras_full  output  1 each  RAS occupancy flags.

Function
REQ-020 Next-addr priority SHALL be: trap_en > jalr_en > (jal_en | br_en) > sequential addr+4.
REQ-021 If jal_en and br_en are both asserted, the target SHALL be addr + jmp_to (single result).
REQ-022 All additions SHALL be modulo 2^XLEN; addr = all-ones-minus-3 plus 4 wraps to 0.
REQ-023 While stall=1 and trap_en=0, addr, misalign and all RAS state SHALL hold; br/jal/jalr/call/ret are ignored.
REQ-024 trap_en SHALL override stall: addr <= trap_vec next edge; RAS untouched.
REQ-025 A selected redirect target (trap, jalr, jal/br) with bits[1:0] != 0 SHALL NOT load addr; addr holds and misalign=1 the following cycle.
REQ-026 misalign SHALL be 1 for exactly one cycle per misaligned event and 0 otherwise, including the next cycle after any non-misaligned update.
REQ-027 addr SHALL update every unstalled cycle with 1-cycle latency from inputs to addr.
REQ-028 RAS push (call_hint, not stalled): write addr+4 at top, count+1; when full, overwrite oldest entry circularly, count stays RAS_DEPTH.
REQ-029 RAS pop (ret_hint, not stalled): remove top, count-1; pop on empty SHALL be ignored.
REQ-030 call_hint and ret_hint together SHALL replace top with addr+4, count unchanged; on empty, act as push only.
REQ-031 RAS ops SHALL apply regardless of redirect selection and of misalignment, but not when trap_en=1.
REQ-032 ras_empty = (count==0); ras_full = (count==RAS_DEPTH); ras_top combinational from stored state.

Reset
REQ-033 rst=1 at a rising edge SHALL set addr=RESET_VEC, addr_vld=0, misalign=0, RAS count=0, ras_top=0.
REQ-034 addr_vld SHALL go to 1 on the first edge with rst=0 and remain 1; addr updates per REQ-020 on that same edge.
REQ-035 rst SHALL take priority over stall, trap_en and all other inputs, including mid-redirect.

Verification
REQ-036 Reset release, no controls, 3 cycles -> addr 0x0, 0x4, 0x8, 0xC; addr_vld 0 then 1.
REQ-037 addr=0x100, jal_en=1, jalr_en=1, jmp_to=0x41 -> addr=0x40 (jalr wins, bit 0 cleared).
REQ-038 addr=0x200, stall=1, br_en=1, jmp_to=0x10, 2 cycles -> addr stays 0x200; then stall=1, trap_en=1, trap_vec=0x800 -> addr=0x800.
REQ-039 addr=0x300, br_en=1, jmp_to=0x6 -> addr stays 0x300, misalign=1 one cycle, then 0.
REQ-040 RAS_DEPTH=4: 5 calls at addr 0x0,0x4,...,0x10 -> ras_full=1, ras_top=0x14; 4 pops -> ras_empty=1; 5th pop ignored.
REQ-041 addr=0xFFFF_FFFC, no controls -> addr=0x0 next cycle.
